// File: rtl/id_if_redirect_queue_pkg.sv
// Shared parameters for the ID->IF redirect queue: PC width, default depth, stat width.
// The optional statistics counters are enabled with the REDIR_STATS_EN macro.
`ifndef WIDTH_PC
`define WIDTH_PC 32
`endif

package id_if_redirect_queue_pkg;
  localparam int WIDTH_PC_DEF  = `WIDTH_PC;
  localparam int REDIR_Q_DEPTH = 2;
  localparam int STAT_W        = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/id_if_redirect_queue_if.sv
// Handshake bundle between ID (producer), the redirect queue and IF (consumer).
interface id_if_redirect_queue_if #(
  parameter int WIDTH_PC = 32,
  parameter int CNT_W    = 2
);
  logic                redir_valid_i;
  logic [WIDTH_PC-1:0] redir_pc_i;
  logic                redir_ready_o;
  logic                redir_valid_o;
  logic [WIDTH_PC-1:0] redir_pc_o;
  logic                redir_ready_i;
  logic                flush_i;
  logic [CNT_W-1:0]    count_o;

  modport slave (
    input  redir_valid_i, redir_pc_i, redir_ready_i, flush_i,
    output redir_ready_o, redir_valid_o, redir_pc_o, count_o
  );

  modport master (
    output redir_valid_i, redir_pc_i, redir_ready_i, flush_i,
    input  redir_ready_o, redir_valid_o, redir_pc_o, count_o
  );
endinterface

// File: rtl/id_if_redirect_queue_redir_sat_counter.sv
// Saturating event counter: adds inc when en is high, clamps at all-ones.
// Only built when REDIR_STATS_EN is defined.
`ifdef REDIR_STATS_EN
module redir_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] val
);
  logic [W:0] sum;

  assign sum = {1'b0, val} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val <= '0;
    end else if (en) begin
      val <= sum[W] ? '1 : sum[W-1:0];
    end
  end
endmodule
`endif

// File: rtl/id_if_redirect_queue.sv
// Queue of ID branch/jump redirect targets handed to IF with valid/ready and flush.
// Optional flush/serve statistics ports are added when REDIR_STATS_EN is defined.
module id_if_redirect_queue
  import id_if_redirect_queue_pkg::*;
#(
  parameter int WIDTH_PC = WIDTH_PC_DEF,
  parameter int DEPTH    = REDIR_Q_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_if_redirect_queue_if.slave q
`ifdef REDIR_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_flushed_o,
  output logic [STAT_W-1:0]    stat_served_o
`endif
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH_PC-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign q.redir_ready_o = (count != CNT_FULL);
  assign q.redir_valid_o = (count != '0);
  assign q.redir_pc_o    = q.redir_valid_o ? mem[rd_ptr] : '0;
  assign q.count_o       = count;

  assign push = q.redir_valid_i & q.redir_ready_o;
  assign pop  = q.redir_valid_o & q.redir_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (q.flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q.redir_pc_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef REDIR_STATS_EN
  // A pop coinciding with a flush is discarded, so it is not counted as served.
  logic served_evt;
  assign served_evt = pop & ~q.flush_i;

  redir_sat_counter #(.W(STAT_W)) u_flushed (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (q.flush_i),
    .inc   (STAT_W'(count)),
    .val   (stat_flushed_o)
  );

  redir_sat_counter #(.W(STAT_W)) u_served (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (served_evt),
    .inc   (STAT_W'(1)),
    .val   (stat_served_o)
  );
`endif
endmodule
